// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the MEM-stage port.
// Define DMEM_ACCESS_STATS_EN to add stat_loads/stat_stores counters.
module dmem_responder #(
  parameter int NUM_WORDS = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores
`endif
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
  localparam bit LAT1 = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [NUM_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             mem_we;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic             op_write;
  logic [IDX_W-1:0] op_idx;
  logic             op_err;

  assign req_ready  = (state_q != BUSY);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid & req_ready;

  // With single-cycle latency the access happens on the accept edge itself
  assign op_addr  = LAT1 ? req_addr  : addr_q;
  assign op_wdata = LAT1 ? req_wdata : wdata_q;
  assign op_write = LAT1 ? req_write : write_q;

  assign op_idx = op_addr[IDX_W+1:2];
  assign op_err = (op_addr[1:0] != 2'b00)
                | ((op_addr >> (IDX_W + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LAT1 ? RESP : BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (accept) begin
          state_d = LAT1 ? RESP : BUSY;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      write_d = req_write;
    end
  end

  // Storage access and response capture happen on the edge entering RESP
  always_comb begin
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    enter_resp = (state_d == RESP);
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = 32'd0;
      if (!op_err && !op_write) begin
        rdata_d = mem_q[op_idx];
      end
      mem_we = !op_err && op_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (mem_we) begin
        mem_q[op_idx] <= op_wdata;
      end
    end
  end

`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0] loads_q, loads_d;
  logic [31:0] stores_q, stores_d;

  // write_q always holds the kind of the request being answered
  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    if (resp_valid) begin
      if (write_q) begin
        stores_d = stores_q + 32'd1;
      end else begin
        loads_d = loads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
`endif

endmodule
